rpn_eval: RTL and testbench
===========================

# rpn_eval

Postfix (RPN) expression evaluator that sits directly downstream of the infix-to-postfix converter and consumes its character stream. It owns a private operand stack and sequences push/pop/compute for each character, including a multi-cycle signed divider. On `=` it emits one W-bit result or an error code, then clears its stack.

## Interface
- `W`, 16: operand/result width, two's complement.
- `DEPTH`, 8: operand stack entries.
- `CLK` in 1: clock, rising edge.
- `RST` in 1: reset. RST is synchronous and active-high.
- `IN_STB` in 1: source has a valid character on `IN_CHAR`.
- `IN_CHAR` in 8: ASCII postfix character.
- `IN_ACK` out 1: ready. A character transfers on an edge where `IN_STB && IN_ACK`.
- `RES_STB` out 1: result valid. Held until taken.
- `RES_DATA` out W: result. 0 when `RES_ERR`=1.
- `RES_ERR` out 1: expression failed.
- `ERR_CODE` out 2: error code.
  - 0: none.
  - 1: stack underflow.
  - 2: stack overflow.
  - 3: divide-by-zero or illegal character.
- `RES_ACK` in 1: sink takes the result on an edge where `RES_STB && RES_ACK`.
- `BUSY` out 1: high in any state other than IDLE and ERR.
- `STK_LVL` out clog2(DEPTH+1): current stack depth.

## Operation
- Operand order: b = top of stack, a = next below. Result is a op b, written to a's slot; depth decreases by 1.
- FSM states: IDLE, EXEC, DIV, OUT, ERR. `IN_ACK` is 1 only in IDLE and ERR.
- Handling in IDLE, by accepted character:
  - Digit `0`–`9`: push the zero-extended value and stay in IDLE. If depth == DEPTH: ERR, code 2, stack unchanged.
  - Space (8'h20): ignored.
  - `+`, `-`, `*`: if depth < 2, go to ERR with code 1. Otherwise go to EXEC.
  - `/`: if depth < 2, go to ERR with code 1. If b == 0, go to ERR with code 3. Otherwise start the divider and go to DIV.
  - `=`: if depth == 1, load top into `RES_DATA`, set `RES_STB`, clear the stack, go to OUT. Depth 0 gives ERR code 1; depth > 1 gives ERR code 2.
  - Any other character: ERR, code 3.
- EXEC: write the result, then return to IDLE.
  - Add, sub, mul wrap modulo 2^W.
  - Mul keeps the low W bits of the product.
- DIV: wait for divider `done`, write the quotient, then return to IDLE.
  - Signed division truncates toward zero.
  - MIN / -1 = MIN.
- OUT: hold `RES_STB`, `RES_DATA`, `RES_ERR`, `ERR_CODE` stable until `RES_ACK`. Then drop `RES_STB`, clear `RES_ERR`/`ERR_CODE`, go to IDLE.
- ERR: `ERR_CODE` is latched on entry. Accept and discard all characters until `=`. On `=`: clear stack, set `RES_STB=1`, `RES_ERR=1`, `RES_DATA=0`, go to OUT.
- Only the first error of an expression is recorded.

## Timing
- Reset values: `IN_ACK=0`, `RES_STB=0`, `RES_DATA=0`, `RES_ERR=0`, `ERR_CODE=0`, `BUSY=0`, `STK_LVL=0`, state IDLE. `IN_ACK` rises in the first cycle after `RST` falls.
- RST at any time aborts EXEC, DIV, or OUT. Any pending result is discarded and the divider is cleared.
- Character throughput:
  - Digit or space: 1 character per cycle sustained.
  - `+ - *`: 2 cycles (accept edge, then EXEC write edge).
  - `/`: W+2 cycles (accept edge, W divider cycles, write edge).
- `=`: `RES_STB` is high in the cycle after the accept edge. The earliest next accept is the cycle after the `RES_ACK` edge.
- `STK_LVL` updates on the same edge as the stack write.

## Configuration
- `RPN_DIV_EN` defined: `/` is supported, and the divider and DIV state are built.
- `RPN_DIV_EN` undefined: the divider and DIV state are not built. `/` is an illegal character: ERR, code 3. All other behaviour is identical.

## Structure
- Shared package `rpn_pkg` holds:
  - ASCII constants: digits, `+ - * / =`, space.
  - FSM state enum.
  - `ERR_CODE` values.
- Sub-module `rpn_div`, parameter W:
  - Sequential restoring divider on operand magnitudes, with sign fixup.
  - Ports: `start`, `a`, `b`, `busy`, `done` (1-cycle pulse), `q`.
  - Takes exactly W cycles from `start` to `done`.
  - Synchronous `RST` clears it.
- The stack is a register array inside `rpn_eval`; no separate module.

## Test plan
- "34+=": `RES_DATA`=7, `RES_ERR`=0. Then "92-3*=": `RES_DATA`=21. Hold `RES_ACK` low for 5 cycles and check that `RES_STB` and `RES_DATA` stay stable.
- "12-=": `RES_DATA`=16'hFFFF. Then "0 9-9*=" (space ignored): `RES_DATA`=16'hFFAF (-81).
- With `RPN_DIV_EN`, "84/=": `RES_DATA`=2, with `IN_ACK` low for W+1 cycles after `/`. "05-2/=": `RES_DATA`=16'hFFFE (-2).
- Error cases:
  - "5+=": `RES_ERR`=1, `ERR_CODE`=1.
  - Nine digits at DEPTH=8: `ERR_CODE`=2, with further characters swallowed until `=`.
  - "50/=": `ERR_CODE`=3.
  - "7a=": `ERR_CODE`=3.
  - Each case is followed by "1=", which must return 1 with no error.
- Assert `RST` mid-DIV and again while `RES_STB`=1. Required response: all outputs at reset values next cycle, then "6=" yields 6.

Source files
------------

// File: rtl/rpn_pkg.sv
// Shared constants and types for the RPN evaluator: ASCII codes, FSM states, error codes.
package rpn_pkg;
    localparam logic [7:0] CH_0   = 8'h30;
    localparam logic [7:0] CH_9   = 8'h39;
    localparam logic [7:0] CH_ADD = 8'h2B;
    localparam logic [7:0] CH_SUB = 8'h2D;
    localparam logic [7:0] CH_MUL = 8'h2A;
    localparam logic [7:0] CH_DIV = 8'h2F;
    localparam logic [7:0] CH_EQ  = 8'h3D;
    localparam logic [7:0] CH_SP  = 8'h20;

    typedef enum logic [2:0] {ST_IDLE, ST_EXEC, ST_DIV, ST_OUT, ST_ERR} state_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_UNDER = 2'd1,
        ERR_OVER  = 2'd2,
        ERR_ILL   = 2'd3
    } err_t;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= CH_0) && (c <= CH_9);
    endfunction
endpackage

// File: rtl/rpn_eval_if.sv
// Character-in / result-out handshake bundle between the evaluator and its neighbours.
interface rpn_eval_if #(parameter int W = 16);
    logic         IN_STB;
    logic [7:0]   IN_CHAR;
    logic         IN_ACK;
    logic         RES_STB;
    logic [W-1:0] RES_DATA;
    logic         RES_ERR;
    logic [1:0]   ERR_CODE;
    logic         RES_ACK;

    modport master (output IN_STB, IN_CHAR, RES_ACK,
                    input  IN_ACK, RES_STB, RES_DATA, RES_ERR, ERR_CODE);
    modport slave  (input  IN_STB, IN_CHAR, RES_ACK,
                    output IN_ACK, RES_STB, RES_DATA, RES_ERR, ERR_CODE);
endinterface

// File: rtl/rpn_div.sv
// Sequential restoring signed divider: magnitudes divided over W cycles, sign applied to the quotient.
module rpn_div #(parameter int W = 16) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] q
);
    localparam int CW = $clog2(W + 1);

    logic [CW-1:0] cnt;
    logic [W-1:0]  rem, quo, dvs;
    logic          neg;
    logic [W:0]    rem_sh, diff;

    assign rem_sh = {rem, quo[W-1]};
    assign diff   = rem_sh - {1'b0, dvs};

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt  <= '0;
            done <= 1'b0;
            rem  <= '0;
            quo  <= '0;
            dvs  <= '0;
            neg  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                cnt <= CW'(W);
                rem <= '0;
                quo <= a[W-1] ? -a : a;
                dvs <= b[W-1] ? -b : b;
                neg <= a[W-1] ^ b[W-1];
            end else if (cnt != '0) begin
                cnt  <= cnt - CW'(1);
                done <= (cnt == CW'(1));
                // A borrow out of the trial subtraction means the divisor did not fit.
                if (!diff[W]) begin
                    rem <= diff[W-1:0];
                    quo <= {quo[W-2:0], 1'b1};
                end else begin
                    rem <= rem_sh[W-1:0];
                    quo <= {quo[W-2:0], 1'b0};
                end
            end
        end
    end

    assign busy = (cnt != '0);
    // |MIN| is representable as an unsigned magnitude, so MIN / -1 naturally returns MIN.
    assign q    = neg ? -quo : quo;
endmodule

// File: rtl/rpn_eval.sv
// Postfix evaluator with a private operand stack; emits one result or error code per '='.
// Define RPN_DIV_EN to build the divider and support '/'; otherwise '/' is an illegal character.
module rpn_eval
    import rpn_pkg::*;
#(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic                       CLK,
    input  logic                       RST,
    rpn_eval_if.slave                  bus,
    output logic                       BUSY,
    output logic [$clog2(DEPTH+1)-1:0] STK_LVL
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    state_t                  state, state_d;
    logic [DEPTH-1:0][W-1:0] stk;
    logic [LW-1:0]           lvl, lvl_m1, lvl_m2;
    logic [W-1:0]            stk_a, stk_b, alu, wr_val, res_val, res_data;
    logic [7:0]              op;
    err_t                    err_code, err_val;
    logic                    res_err, res_err_d;
    logic                    acc, push, wr_a, do_clear, res_load, err_set, op_ld, ack_res;
    logic                    div_start, div_done, div_busy;
    logic [W-1:0]            div_q;

    assign acc    = bus.IN_STB && bus.IN_ACK;
    assign lvl_m1 = lvl - LW'(1);
    assign lvl_m2 = lvl - LW'(2);
    assign stk_b  = stk[lvl_m1[AW-1:0]];
    assign stk_a  = stk[lvl_m2[AW-1:0]];

    always_comb begin
        case (op)
            CH_ADD:  alu = stk_a + stk_b;
            CH_SUB:  alu = stk_a - stk_b;
            default: alu = stk_a * stk_b;
        endcase
    end

`ifdef RPN_DIV_EN
    rpn_div #(.W(W)) u_div (
        .CLK   (CLK),
        .RST   (RST),
        .start (div_start),
        .a     (stk_a),
        .b     (stk_b),
        .busy  (div_busy),
        .done  (div_done),
        .q     (div_q)
    );
`else
    assign div_busy = 1'b0;
    assign div_done = 1'b0;
    assign div_q    = '0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d   = state;
        push      = 1'b0;
        wr_a      = 1'b0;
        wr_val    = alu;
        do_clear  = 1'b0;
        res_load  = 1'b0;
        res_val   = '0;
        res_err_d = 1'b0;
        err_set   = 1'b0;
        err_val   = ERR_NONE;
        op_ld     = 1'b0;
        div_start = 1'b0;
        ack_res   = 1'b0;
        case (state)
            ST_IDLE: if (acc) begin
                if (is_digit(bus.IN_CHAR)) begin
                    if (lvl == LW'(DEPTH)) begin
                        state_d = ST_ERR; err_set = 1'b1; err_val = ERR_OVER;
                    end else begin
                        push = 1'b1;
                    end
                end else begin
                    case (bus.IN_CHAR)
                        CH_SP: ;
                        CH_ADD, CH_SUB, CH_MUL:
                            if (lvl < LW'(2)) begin
                                state_d = ST_ERR; err_set = 1'b1; err_val = ERR_UNDER;
                            end else begin
                                state_d = ST_EXEC; op_ld = 1'b1;
                            end
`ifdef RPN_DIV_EN
                        CH_DIV:
                            if (lvl < LW'(2)) begin
                                state_d = ST_ERR; err_set = 1'b1; err_val = ERR_UNDER;
                            end else if (stk_b == '0) begin
                                state_d = ST_ERR; err_set = 1'b1; err_val = ERR_ILL;
                            end else begin
                                state_d = ST_DIV; div_start = 1'b1;
                            end
`endif
                        CH_EQ:
                            if (lvl == LW'(1)) begin
                                state_d  = ST_OUT;
                                res_load = 1'b1;
                                res_val  = stk_b;
                                do_clear = 1'b1;
                            end else begin
                                state_d = ST_ERR;
                                err_set = 1'b1;
                                err_val = (lvl == '0) ? ERR_UNDER : ERR_OVER;
                            end
                        default: begin
                            state_d = ST_ERR; err_set = 1'b1; err_val = ERR_ILL;
                        end
                    endcase
                end
            end
            ST_EXEC: begin
                wr_a    = 1'b1;
                state_d = ST_IDLE;
            end
`ifdef RPN_DIV_EN
            ST_DIV: if (div_done) begin
                wr_a    = 1'b1;
                wr_val  = div_q;
                state_d = ST_IDLE;
            end
`endif
            ST_OUT: if (bus.RES_ACK) begin
                ack_res = 1'b1;
                state_d = ST_IDLE;
            end
            // The error code stays as latched on entry; everything up to '=' is swallowed.
            ST_ERR: if (acc && bus.IN_CHAR == CH_EQ) begin
                state_d   = ST_OUT;
                res_load  = 1'b1;
                res_err_d = 1'b1;
                do_clear  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            lvl      <= '0;
            op       <= '0;
            res_data <= '0;
            res_err  <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            if (push) begin
                stk[lvl[AW-1:0]] <= W'(bus.IN_CHAR - CH_0);
                lvl              <= lvl + LW'(1);
            end
            if (wr_a) begin
                stk[lvl_m2[AW-1:0]] <= wr_val;
                lvl                 <= lvl_m1;
            end
            if (do_clear) lvl <= '0;
            if (op_ld)    op  <= bus.IN_CHAR;
            if (err_set)  err_code <= err_val;
            if (res_load) begin
                res_data <= res_val;
                res_err  <= res_err_d;
            end
            if (ack_res) begin
                res_err  <= 1'b0;
                err_code <= ERR_NONE;
            end
        end
    end

    always_comb begin
        bus.IN_ACK   = !RST && (state == ST_IDLE || state == ST_ERR);
        bus.RES_STB  = (state == ST_OUT);
        bus.RES_DATA = res_data;
        bus.RES_ERR  = res_err;
        bus.ERR_CODE = err_code;
        BUSY         = (state != ST_IDLE && state != ST_ERR) || div_busy;
        STK_LVL      = lvl;
    end
endmodule

// File: tb/tb_rpn_eval.sv
// Scoreboard bench for rpn_eval: expressions push expected results, a monitor pops and checks them.
module tb_rpn_eval;
    localparam int W = 16;
    localparam int DEPTH = 8;

    typedef struct {
        logic [W-1:0] d;
        logic         e;
        logic [1:0]   c;
        int           hold;
    } exp_t;

    logic   CLK = 1'b0;
    logic   RST;
    logic   BUSY;
    logic [3:0] STK_LVL;
    int     checks = 0;
    int     errors = 0;
    bit     mon_en = 1'b1;
    exp_t   sb[$];

    rpn_eval_if #(.W(W)) bus ();

    rpn_eval #(.W(W), .DEPTH(DEPTH)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .bus     (bus),
        .BUSY    (BUSY),
        .STK_LVL (STK_LVL)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic expect_res(input logic [W-1:0] d, input logic e, input logic [1:0] c, input int hold);
        exp_t x;
        x.d = d; x.e = e; x.c = c; x.hold = hold;
        sb.push_back(x);
    endtask

    task automatic send_char(input byte c);
        int n;
        @(negedge CLK);
        bus.IN_STB  = 1'b1;
        bus.IN_CHAR = c;
        n = 0;
        while (!bus.IN_ACK) begin
            if (n >= 400) begin
                checks++; errors++;
                $display("FAIL in_ack_timeout: char %0h never accepted", c);
                break;
            end
            @(negedge CLK);
            n++;
        end
        @(posedge CLK);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    task automatic idle_in();
        @(negedge CLK);
        bus.IN_STB = 1'b0;
    endtask

    task automatic run(input string s, input logic [W-1:0] d, input logic e, input logic [1:0] c);
        expect_res(d, e, c, 0);
        send_str(s);
        idle_in();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ack"},   bus.IN_ACK, 0);
        chk({tag, "_res_stb"},  bus.RES_STB, 0);
        chk({tag, "_res_data"}, bus.RES_DATA, 0);
        chk({tag, "_res_err"},  bus.RES_ERR, 0);
        chk({tag, "_err_code"}, bus.ERR_CODE, 0);
        chk({tag, "_busy"},     BUSY, 0);
        chk({tag, "_stk_lvl"},  STK_LVL, 0);
    endtask

    // Monitor: compares every presented result against the scoreboard head, then acknowledges.
    initial begin
        exp_t x;
        bus.RES_ACK = 1'b0;
        forever begin
            @(negedge CLK);
            if (mon_en && bus.RES_STB) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_result: data %0h with empty scoreboard", bus.RES_DATA);
                end else begin
                    x = sb.pop_front();
                    chk("res_data", bus.RES_DATA, x.d);
                    chk("res_err",  bus.RES_ERR, x.e);
                    chk("err_code", bus.ERR_CODE, x.c);
                    for (int k = 0; k < x.hold; k++) begin
                        @(negedge CLK);
                        chk("hold_stb",  bus.RES_STB, 1);
                        chk("hold_data", bus.RES_DATA, x.d);
                    end
                end
                bus.RES_ACK = 1'b1;
                @(negedge CLK);
                bus.RES_ACK = 1'b0;
                chk("stb_drop", bus.RES_STB, 0);
            end
        end
    end

    initial begin
        int n;
        RST = 1'b1;
        bus.IN_STB = 1'b0;
        bus.IN_CHAR = 8'h00;
        repeat (3) @(negedge CLK);
        chk_reset_vals("rst0");
        RST = 1'b0;
        #1 chk("in_ack_after_rst", bus.IN_ACK, 1);

        run("34+=", 16'd7, 1'b0, 2'd0);
        expect_res(16'd21, 1'b0, 2'd0, 5);
        send_str("92-3*=");
        idle_in();
        run("12-=", 16'hFFFF, 1'b0, 2'd0);
        run("0 9-9*=", 16'hFFAF, 1'b0, 2'd0);

        run("5+=", 16'd0, 1'b1, 2'd1);
        run("1=", 16'd1, 1'b0, 2'd0);

        // Overflow on the ninth digit; later characters (including a would-be illegal one) are swallowed.
        expect_res(16'd0, 1'b1, 2'd2, 0);
        send_str("123456789");
        @(negedge CLK);
        chk("ovf_lvl", STK_LVL, 8);
        chk("ovf_code_latched", bus.ERR_CODE, 2);
        send_str("+a");
        @(negedge CLK);
        chk("ovf_swallow_lvl", STK_LVL, 8);
        send_str("=");
        idle_in();
        run("1=", 16'd1, 1'b0, 2'd0);

        run("7a=", 16'd0, 1'b1, 2'd3);
        run("1=", 16'd1, 1'b0, 2'd0);

`ifdef RPN_DIV_EN
        expect_res(16'd2, 1'b0, 2'd0, 0);
        send_str("84/");
        n = 0;
        @(negedge CLK);
        while (!bus.IN_ACK && n < 100) begin
            n++;
            @(negedge CLK);
        end
        chk("div_ack_low_cycles", n, W + 1);
        send_str("=");
        idle_in();
        run("05-2/=", 16'hFFFE, 1'b0, 2'd0);
        run("50/=", 16'd0, 1'b1, 2'd3);
        run("1=", 16'd1, 1'b0, 2'd0);

        // Reset in the middle of a division.
        send_str("84/");
        repeat (3) @(negedge CLK);
        chk("mid_div_busy", BUSY, 1);
        RST = 1'b1;
        bus.IN_STB = 1'b0;
        @(negedge CLK);
        chk_reset_vals("rst_div");
        RST = 1'b0;
        run("6=", 16'd6, 1'b0, 2'd0);
`else
        run("84/=", 16'd0, 1'b1, 2'd3);
        run("1=", 16'd1, 1'b0, 2'd0);
`endif

        // Reset while a result is being presented; it must be discarded.
        mon_en = 1'b0;
        send_str("5=");
        idle_in();
        n = 0;
        while (!bus.RES_STB && n < 50) begin
            n++;
            @(negedge CLK);
        end
        chk("out_stb_seen", bus.RES_STB, 1);
        chk("out_data_seen", bus.RES_DATA, 5);
        RST = 1'b1;
        @(negedge CLK);
        chk_reset_vals("rst_out");
        RST = 1'b0;
        mon_en = 1'b1;
        run("6=", 16'd6, 1'b0, 2'd0);

        n = 0;
        while (sb.size() != 0 && n < 500) begin
            n++;
            @(negedge CLK);
        end
        chk("scoreboard_drained", sb.size(), 0);
        repeat (2) @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
